// File: rtl/adxl362_resp_pkg.sv
// Shared constants, register map and FSM encoding for the ADXL362 SPI responder.
package adxl362_resp_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;

  localparam logic [7:0] ADDR_REVID     = 8'h03;
  localparam logic [7:0] ADDR_XDATA     = 8'h08;
  localparam logic [7:0] ADDR_YDATA     = 8'h09;
  localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_SOFT_RST  = 8'h1F;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_LO         = 8'h20;
  localparam logic [7:0] REG_HI         = 8'h2E;

  localparam logic [7:0] REVID_VAL      = 8'h01;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  localparam int unsigned REG_COUNT     = 15;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_t;

  function automatic logic is_writable(input logic [7:0] a);
    return (a >= REG_LO) && (a <= REG_HI);
  endfunction

  function automatic logic is_xyz(input logic [7:0] a);
    return (a >= ADDR_XDATA) && (a <= ADDR_ZDATA);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// o_level is the delayed copy so it lines up with the edge pulses.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface model: oversampled SPI mode-0 responder with
// ID/sample/STATUS read map, writable 0x20-0x2E block and tear-free sample shadow.
module adxl362_spi_responder
  import adxl362_resp_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] sample_x,
  input  logic [7:0] sample_y,
  input  logic [7:0] sample_z,
  input  logic       sample_valid,
  output logic [7:0] power_ctl,
  output logic       measure_en,
  output logic       txn_done
);

  localparam logic [3:0] PWR_IDX = 4'(ADDR_POWER_CTL - REG_LO);

  logic w_csn_lvl, w_csn_rise, w_csn_fall;
  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .arst(arst), .i_pin(spi_csn),
    .o_level(w_csn_lvl), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .arst(arst), .i_pin(spi_sclk),
    .o_level(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .arst(arst), .i_pin(spi_mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_t     r_state, w_next;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_addr;
  logic [7:0] r_tx;
  logic       r_is_read;
  logic       r_xyz_read;

  logic [7:0] r_regs [REG_COUNT];
  logic [7:0] r_shadow_x, r_shadow_y, r_shadow_z;
  logic [7:0] r_pend_x, r_pend_y, r_pend_z;
  logic       r_pending;
  logic       r_drdy;

  logic       w_active;
  logic       w_bit;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic       w_wr_commit;
  logic       w_soft_reset;
  logic       w_copy;
  logic [7:0] w_rd_addr;
  logic [7:0] w_rd_data;

  assign w_active     = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
  assign w_bit        = w_active && w_sclk_rise && !w_csn_rise;
  assign w_byte_done  = w_bit && (r_bitcnt == 3'd7);
  assign w_rx_byte    = {r_shift[6:0], w_mosi};
  assign w_wr_commit  = w_byte_done && (r_state == DATA) && !r_is_read;
  assign w_soft_reset = w_wr_commit && (r_addr == ADDR_SOFT_RST) && (w_rx_byte == SOFT_RESET_KEY);
  assign w_copy       = (r_state == IDLE) && r_pending;

  // Byte to preload into MISO: the address just received, or the next in the burst.
  assign w_rd_addr = (r_state == ADDR) ? w_rx_byte : r_addr + 8'd1;

  always_comb begin
    w_rd_data = '0;
    if (is_writable(w_rd_addr)) begin
      w_rd_data = r_regs[4'(w_rd_addr - REG_LO)];
    end else begin
      unique case (w_rd_addr)
        8'h00:       w_rd_data = DEVID_AD;
        8'h01:       w_rd_data = DEVID_MST;
        8'h02:       w_rd_data = PARTID;
        ADDR_REVID:  w_rd_data = REVID_VAL;
        ADDR_XDATA:  w_rd_data = r_shadow_x;
        ADDR_YDATA:  w_rd_data = r_shadow_y;
        ADDR_ZDATA:  w_rd_data = r_shadow_z;
        ADDR_STATUS: w_rd_data = {7'b0, r_drdy};
        default:     w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_csn_rise) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_csn_fall) w_next = CMD;
        CMD:     if (w_byte_done)
                   w_next = ((w_rx_byte == CMD_READ) || (w_rx_byte == CMD_WRITE)) ? ADDR : IGNORE;
        ADDR:    if (w_byte_done) w_next = DATA;
        DATA:    w_next = DATA;
        IGNORE:  w_next = IGNORE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    spi_miso    = 1'b0;
    spi_miso_oe = ~w_csn_lvl;
    txn_done    = w_csn_rise;
    if ((r_state == DATA) && r_is_read) spi_miso = r_tx[7];
  end

  // The fall that follows a completed byte must not shift: the freshly loaded
  // MSB has to stay on MISO until the next rising edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_is_read  <= 1'b0;
      r_xyz_read <= 1'b0;
    end else if (w_csn_fall) begin
      r_bitcnt   <= '0;
      r_tx       <= '0;
      r_is_read  <= 1'b0;
      r_xyz_read <= 1'b0;
    end else if (w_bit) begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_shift  <= w_rx_byte;
      if (w_byte_done) begin
        unique case (r_state)
          CMD:  r_is_read <= (w_rx_byte == CMD_READ);
          ADDR: begin
            r_addr <= w_rx_byte;
            if (r_is_read) r_tx <= w_rd_data;
          end
          DATA: begin
            r_addr <= r_addr + 8'd1;
            if (r_is_read) begin
              r_tx <= w_rd_data;
              if (is_xyz(r_addr)) r_xyz_read <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (w_sclk_fall && (r_state == DATA) && (r_bitcnt != 3'd0)) begin
      r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_pend_z   <= '0;
      r_pending  <= 1'b0;
      r_shadow_x <= '0;
      r_shadow_y <= '0;
      r_shadow_z <= '0;
      r_drdy     <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_pend_x <= sample_x;
        r_pend_y <= sample_y;
        r_pend_z <= sample_z;
      end
      r_pending <= sample_valid | (r_pending & ~w_copy);
      if (w_copy) begin
        r_shadow_x <= r_pend_x;
        r_shadow_y <= r_pend_y;
        r_shadow_z <= r_pend_z;
      end
      if (w_copy)                        r_drdy <= 1'b1;
      else if (w_soft_reset)             r_drdy <= 1'b0;
      else if (w_csn_rise && r_xyz_read) r_drdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_soft_reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_wr_commit && is_writable(r_addr)) begin
      r_regs[4'(r_addr - REG_LO)] <= w_rx_byte;
    end
  end

  assign power_ctl  = r_regs[PWR_IDX];
  assign measure_en = (power_ctl[1:0] == 2'b10);

endmodule
